// File: rtl/nd_link_pkg.sv
// nd_link_pkg: shared constants and state encoding for the note-data serial link
package nd_link_pkg;
  localparam int NOTE_LANES = 37;
  localparam int FRAME_BITS = 40;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/nd_bit_timer.sv
// nd_bit_timer: free-running bit-period counter 0..BIT_CYCLES-1 with clear and tick
module nd_bit_timer
  import nd_link_pkg::*;
#(
  parameter int BIT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  logic [15:0] count;
  assign tick = count == 16'(BIT_CYCLES - 1);
  // count one bit period, restarting on clear or at the end of each period
  always_ff @(posedge clk) begin
    if (!rst_n || clear || tick) count <= '0;
    else count <= count + 16'd1;
  end
endmodule

// File: rtl/nd_link_serializer.sv
// nd_link_serializer: one-deep buffered 37-bit note frame to async serial line (start, data LSB first, even parity, stop)
module nd_link_serializer
  import nd_link_pkg::*;
#(
  parameter int BIT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NOTE_LANES-1:0] ndata_in,
  input  logic                  ndata_valid,
  output logic                  ndata_ready,
  output logic                  sdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);
  if (BIT_CYCLES < 2 || BIT_CYCLES > 65535) begin : g_bad_bit_cycles
    $error("nd_link_serializer: BIT_CYCLES must be 2..65535");
  end
  state_t                state;
  logic [NOTE_LANES-1:0] hold;
  logic [NOTE_LANES-1:0] shift;
  logic                  hold_full;
  logic                  par;
  logic                  tick;
  logic                  load;
  logic [5:0]            idx;
  assign ndata_ready = !hold_full;
  assign load = hold_full && (state == IDLE || (state == STOP && tick));
  nd_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .tick (tick)
  );
  // accept into the holding register, walk the frame bits, and reload back-to-back from the buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      hold_full   <= 1'b0;
      shift       <= '0;
      par         <= 1'b0;
      idx         <= '0;
      sdata       <= IDLE_LEVEL;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (ndata_valid && !hold_full) begin
        hold      <= ndata_in;
        hold_full <= 1'b1;
      end
      case (state)
        START: if (tick) begin
          state <= DATA;
          idx   <= '0;
          sdata <= shift[0];
        end
        DATA: if (tick) begin
          shift <= shift >> 1;
          idx   <= idx + 6'd1;
          state <= idx == 6'(NOTE_LANES - 1) ? PARITY : DATA;
          sdata <= idx == 6'(NOTE_LANES - 1) ? par : shift[1];
        end
        PARITY: if (tick) begin
          state <= STOP;
          sdata <= STOP_LEVEL;
        end
        STOP: if (tick) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
          state       <= IDLE;
          busy        <= 1'b0;
          sdata       <= IDLE_LEVEL;
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        shift     <= hold;
        par       <= ^hold;
        hold_full <= 1'b0;
        state     <= START;
        sdata     <= START_LEVEL;
        busy      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nd_link_serializer.sv
// tb_nd_link_serializer: randomized frame streams checked against a wire-level timeline model
module tb_nd_link_serializer;
  localparam int BC = 4;
  localparam int FC = 40 * BC;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [36:0] ndata_in = '0;
  logic        ndata_valid = 1'b0;
  logic        ndata_ready;
  logic        sdata;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  nd_link_serializer #(.BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ndata_in   (ndata_in),
    .ndata_valid(ndata_valid),
    .ndata_ready(ndata_ready),
    .sdata      (sdata),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] rand37();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[36:0];
  endfunction

  // level of wire bit b (0..39) of a frame carrying d
  function automatic logic wire_bit(input logic [36:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 37) return d[b-1];
    if (b == 38) return ^d;
    return 1'b1;
  endfunction

  // n frames: A offered at k=0, B offered for one cycle at k=b_at, C held valid with a
  // changing value from c_from until the cycle it can be taken; every cycle is checked
  task automatic stream(input string name, input int n, input logic [36:0] fa,
                        input logic [36:0] fb, input int b_at, input int c_from,
                        output logic par_seen);
    int s[3];
    int a[3];
    logic [36:0] f[3];
    int last;
    logic ew, eb, ed, er;
    f[0] = fa;
    f[1] = fb;
    f[2] = '0;
    for (int i = 0; i < 3; i++) s[i] = 2 + FC * i;
    a[0] = 1;
    a[1] = b_at + 1;
    a[2] = FC + 3;
    last = s[n-1] + FC + 1;
    par_seen = 1'bx;
    @(negedge clk);
    vectors++;
    if (ndata_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_at_offer got %b exp 1", name, ndata_ready);
    end
    ndata_in = fa;
    ndata_valid = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      ew = 1'b1;
      eb = 1'b0;
      ed = 1'b0;
      er = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (k >= s[i] && k < s[i] + FC) begin
          ew = wire_bit(f[i], (k - s[i]) / BC);
          eb = 1'b1;
        end
        if (k == s[i] + FC) ed = 1'b1;
        if (k >= a[i] && k < s[i]) er = 1'b0;
      end
      if (k == s[0] + 38 * BC) par_seen = sdata;
      vectors++;
      if (sdata !== ew) begin
        miscompares++;
        $display("FAIL %s sdata k=%0d got %b exp %b", name, k, sdata, ew);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL %s busy k=%0d got %b exp %b", name, k, busy, eb);
      end
      vectors++;
      if (frame_done !== ed) begin
        miscompares++;
        $display("FAIL %s frame_done k=%0d got %b exp %b", name, k, frame_done, ed);
      end
      vectors++;
      if (ndata_ready !== er) begin
        miscompares++;
        $display("FAIL %s ready k=%0d got %b exp %b", name, k, ndata_ready, er);
      end
      ndata_valid = 1'b0;
      ndata_in = rand37();
      if (n > 1 && k == b_at) begin
        ndata_valid = 1'b1;
        ndata_in = fb;
      end
      if (n > 2 && k >= c_from && k <= FC + 2) begin
        ndata_valid = 1'b1;
        if (k == FC + 2) f[2] = ndata_in;
      end
    end
    ndata_valid = 1'b0;
    exp_cnt = exp_cnt + 16'(n);
    vectors++;
    if (frame_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s frame_count got %h exp %h", name, frame_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (sdata !== 1'b1) begin miscompares++; $display("FAIL reset sdata got %b exp 1", sdata); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
    vectors++;
    if (frame_count !== 16'h0) begin miscompares++; $display("FAIL reset frame_count got %h exp 0", frame_count); end
    vectors++;
    if (ndata_ready !== 1'b1) begin miscompares++; $display("FAIL reset ready got %b exp 1", ndata_ready); end
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_single();
    logic p;
    stream("single", 1, 37'h0_0000_0001, '0, 0, 0, p);
  endtask

  task automatic test_parity();
    logic p;
    stream("parity_ones", 1, 37'h1F_FFFF_FFFF, '0, 0, 0, p);
    vectors++;
    if (p !== 1'b1) begin miscompares++; $display("FAIL parity_ones bit got %b exp 1", p); end
    stream("parity_zero", 1, 37'h0, '0, 0, 0, p);
    vectors++;
    if (p !== 1'b0) begin miscompares++; $display("FAIL parity_zero bit got %b exp 0", p); end
  endtask

  task automatic test_back_to_back();
    logic p;
    stream("back_to_back", 2, rand37(), rand37(), 30, 0, p);
  endtask

  task automatic test_backpressure();
    logic p;
    int b;
    b = 6 + int'($urandom_range(0, 140));
    stream("backpressure", 3, rand37(), rand37(), b, b + 1 + int'($urandom_range(0, 10)), p);
  endtask

  task automatic test_random();
    logic p;
    int b;
    for (int r = 0; r < 3; r++) begin
      b = 6 + int'($urandom_range(0, 147));
      stream("random", 1 + int'($urandom_range(0, 2)), rand37(), rand37(), b,
             b + 1 + int'($urandom_range(0, FC + 1 - b)), p);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [36:0] fa;
    logic p;
    fa = rand37();
    @(negedge clk);
    ndata_in = fa;
    ndata_valid = 1'b1;
    for (int k = 1; k <= 2 + 11 * BC + 1; k++) begin
      @(negedge clk);
      ndata_valid = 1'b0;
      ndata_in = rand37();
    end
    vectors++;
    if (sdata !== fa[10] || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame data_bit10 got %b/%b exp %b/1", sdata, busy, fa[10]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (sdata !== 1'b1) begin miscompares++; $display("FAIL mid_reset sdata got %b exp 1", sdata); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset busy got %b exp 0", busy); end
    vectors++;
    if (ndata_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset ready got %b exp 1", ndata_ready); end
    vectors++;
    if (frame_count !== 16'h0) begin miscompares++; $display("FAIL mid_reset frame_count got %h exp 0", frame_count); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_reset frame_done got %b exp 0", frame_done); end
    rst_n = 1'b1;
    exp_cnt = '0;
    stream("after_reset", 1, rand37(), '0, 0, 0, p);
  endtask

  task automatic test_wrap();
    logic p;
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    vectors++;
    if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap preload got %h exp ffff", frame_count); end
    exp_cnt = 16'hFFFF;
    stream("wrap", 1, rand37(), '0, 0, 0, p);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nd_link_serializer.md
Name: nd_link_serializer

Overview:
- Transmit end of the note-data link that feeds the score/compare block's 37-lane NDATA input.
- Accepts a 37-bit note frame (one bit per note lane) through a valid/ready handshake.
- Buffers one frame and shifts each frame out on a single wire as an idle-high asynchronous frame: start bit, 37 data bits LSB first, even parity bit, stop bit.
- Sits on the game-logic side, ahead of the link deserializer that produces NDATA.

Parameters:
- BIT_CYCLES, 100: clk cycles per serial bit (100 MHz / 100 = 1 Mbit/s). Legal range is 2..65535. Values outside the range fail elaboration.
- NOTE_LANES, 37: data bits per frame. The design is fixed to 37 and must match the receiver's NDATA width.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  synchronous active-low reset
- ndata_in  in  37  note frame to send; bit 0 goes on the wire first
- ndata_valid  in  1  ndata_in is valid
- ndata_ready  out  1  holding register empty; a frame is accepted when valid && ready at a rising edge
- sdata  out  1  serial line, registered output, idles high
- busy  out  1  high while a frame is on the wire (START through STOP)
- frame_done  out  1  one-cycle pulse at the end of each stop bit
- frame_count  out  16  number of completed frames, wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (rst_n low at a rising edge) applies at that edge:
  - sdata=1, busy=0, frame_done=0, frame_count=0, ndata_ready=1.
  - Holding register cleared; FSM goes to IDLE; bit timer = 0.
  - If a frame is mid-transmission, it is abandoned and the line returns high; no frame_done pulse.
- ndata_ready = !hold_full, combinational from a register. An accept at edge E sets hold_full after E.
- The FSM has five states; at every state the timer runs 0..BIT_CYCLES-1 and the state advances on tick (timer == BIT_CYCLES-1):
  - IDLE: sdata=1, timer held at 0. If hold_full: move the holding register into the shifter, compute parity, clear hold_full, go to START. sdata=0 takes effect at the same edge.
  - START: sdata=0 for BIT_CYCLES; on tick go to DATA with bit index 0.
  - DATA: sdata=shift[0]; on tick shift right and increment the index; after index 36 completes, go to PARITY.
  - PARITY: sdata = XOR of the 37 data bits (even parity over data+parity); on tick go to STOP.
  - STOP: sdata=1; on tick pulse frame_done and increment frame_count. Then:
    - if hold_full: reload and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Latency: with the FSM idle, an accept at edge E gives sdata=0 after E+1. A full frame occupies exactly 40*BIT_CYCLES cycles on the wire.
- There is no same-cycle accept and transfer: while hold_full=1, ready=0, so an accept can only happen after the transfer into the shifter has cleared hold_full.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
- The holding register stays stable while full. ndata_in is ignored when ready=0.
- ndata_valid may deassert without a frame being accepted. The block places no requirement on the producer.

Decomposition:
- Shared package nd_link_pkg, containing:
  - NOTE_LANES=37; FRAME_BITS=40;
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1. The receiver uses the same package.
- One sub-module: nd_bit_timer, a counter 0..BIT_CYCLES-1 with a clear input and a tick output, reused by the deserializer.

Test Plan:
- Single frame, BIT_CYCLES=4, ndata_in=37'h0_0000_0001 -> 160 cycles on the wire:
  - sdata: 0 for 4 cycles, then 1 for 4 (D0), then 0 for 144 (D1..D36), then parity 1 for 4, then stop 1 for 4;
  - frame_done pulses once; frame_count=1.
- Parity check, ndata_in=37'h1F_FFFF_FFFF (37 ones) -> parity bit = 1. ndata_in=37'h0 -> parity bit = 0 and all 38 bits after the start bit are 0 except the stop bit.
- Back-to-back: accept frame A, then accept frame B while A is in DATA. Required:
  - ndata_ready=0 from B's accept until A's STOP tick;
  - B's start bit follows A's stop bit with no idle cycle;
  - 320 wire cycles total; frame_count=2.
- Backpressure: hold valid high with a new value while ready=0. The accepted value must be the one present at the ready=1 edge; no frame is dropped or duplicated.
- Reset mid-frame: assert rst_n=0 during DATA bit 10. Next cycle sdata=1, busy=0, ready=1, frame_count=0, no frame_done. A new frame after release transmits normally.
- Wrap: preload by running 65536 frames (or force frame_count=16'hFFFF in sim) and complete one frame -> frame_count=0.
